// File: rtl/event_queue.sv
`default_nettype none
// ============================================================================
//  Module   : event_queue
//  Purpose  : Merges two single-cycle event strobes (A = button/pedal, which
//             has priority, and B = keypad) into one first-word-fall-through
//             FIFO. The host drains the FIFO with an asynchronous level
//             read request. Provides an interrupt, the fill level and a
//             sticky overflow flag.
//  Ports    : clk        - 1 MHz clock, all logic on posedge
//             rst        - asynchronous active-high reset
//             evtFlagA   - 1-cycle strobe, source A (priority)
//             evtCodeA   - code for source A, valid with evtFlagA
//             evtFlagB   - 1-cycle strobe, source B
//             evtCodeB   - code for source B, valid with evtFlagB
//             rdReq      - async level; each rising edge pops one entry
//             clrOvf     - 1-cycle pulse, clears overflow
//             rdData     - head entry, 0 when empty
//             dataValid  - FIFO not empty
//             irq        - interrupt, equals dataValid
//             overflow   - sticky, an event was dropped
//             count      - number of stored entries, 0..DEPTH
//  Revision : 1.0 - initial release
// ============================================================================
module event_queue #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              evtFlagA,
  input  logic [DATA_W-1:0] evtCodeA,
  input  logic              evtFlagB,
  input  logic [DATA_W-1:0] evtCodeB,
  input  logic              rdReq,
  input  logic              clrOvf,
  output logic [DATA_W-1:0] rdData,
  output logic              dataValid,
  output logic              irq,
  output logic              overflow,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W:0]   c_fullCount = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   c_countOne  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] c_ptrOne    = ADDR_W'(1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wrPtr;
  logic [ADDR_W-1:0] r_rdPtr;
  logic [ADDR_W:0]   r_count;
  logic              r_overflow;
  logic              r_pendValid;
  logic [DATA_W-1:0] r_pendData;
  logic              r_rdSync1;
  logic              r_rdSync2;
  logic              r_rdPrev;

  logic              w_wrEn;
  logic [DATA_W-1:0] w_wrData;
  logic              w_pendLoad;
  logic              w_pendClr;
  logic              w_bDrop;
  logic              w_full;
  logic              w_pop;
  logic              w_wrOk;
  logic              w_fullDrop;

  // Single FIFO write slot per cycle. A owns it whenever it strobes; otherwise
  // a parked B entry drains before any newly arriving B, which is parked in
  // its place. A B that finds the park slot busy while A holds the write
  // slot has nowhere to go and is dropped.
  always_comb begin
    w_wrEn     = 1'b0;
    w_wrData   = '0;
    w_pendLoad = 1'b0;
    w_pendClr  = 1'b0;
    w_bDrop    = 1'b0;
    if (evtFlagA) begin
      w_wrEn   = 1'b1;
      w_wrData = evtCodeA;
      if (evtFlagB) begin
        if (r_pendValid) w_bDrop    = 1'b1;
        else             w_pendLoad = 1'b1;
      end
    end else if (r_pendValid) begin
      w_wrEn   = 1'b1;
      w_wrData = r_pendData;
      if (evtFlagB) w_pendLoad = 1'b1;
      else          w_pendClr  = 1'b1;
    end else if (evtFlagB) begin
      w_wrEn   = 1'b1;
      w_wrData = evtCodeB;
    end
  end

  // Pop is judged on the pre-write occupancy, so a write into an empty
  // FIFO cannot be popped in the same cycle.
  assign w_full     = (r_count == c_fullCount);
  assign w_pop      = r_rdSync2 & ~r_rdPrev & (r_count != '0);
  assign w_wrOk     = w_wrEn & (~w_full | w_pop);
  assign w_fullDrop = w_wrEn & w_full & ~w_pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdSync1 <= 1'b0;
      r_rdSync2 <= 1'b0;
      r_rdPrev  <= 1'b0;
    end else begin
      r_rdSync1 <= rdReq;
      r_rdSync2 <= r_rdSync1;
      r_rdPrev  <= r_rdSync2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pendValid <= 1'b0;
      r_pendData  <= '0;
    end else if (w_pendLoad) begin
      r_pendValid <= 1'b1;
      r_pendData  <= evtCodeB;
    end else if (w_pendClr) begin
      r_pendValid <= 1'b0;
    end
  end

  // Storage needs no reset: contents are only visible through the pointers.
  always_ff @(posedge clk) begin
    if (w_wrOk) r_mem[r_wrPtr] <= w_wrData;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wrOk) r_wrPtr <= r_wrPtr + c_ptrOne;
      if (w_pop)  r_rdPtr <= r_rdPtr + c_ptrOne;
      case ({w_wrOk, w_pop})
        2'b10:   r_count <= r_count + c_countOne;
        2'b01:   r_count <= r_count - c_countOne;
        default: r_count <= r_count;
      endcase
      // A drop in the same cycle as clrOvf keeps the flag set.
      if (w_fullDrop || w_bDrop) r_overflow <= 1'b1;
      else if (clrOvf)           r_overflow <= 1'b0;
    end
  end

  assign dataValid = (r_count != '0);
  assign irq       = dataValid;
  assign rdData    = dataValid ? r_mem[r_rdPtr] : '0;
  assign overflow  = r_overflow;
  assign count     = r_count;

endmodule
`default_nettype wire

// File: tb/tb_event_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_event_queue
//  Purpose  : Directed self-checking bench for event_queue.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_event_queue;

  logic       clk;
  logic       rst;
  logic       evtFlagA;
  logic [7:0] evtCodeA;
  logic       evtFlagB;
  logic [7:0] evtCodeB;
  logic       rdReq;
  logic       clrOvf;
  logic [7:0] rdData;
  logic       dataValid;
  logic       irq;
  logic       overflow;
  logic [3:0] count;

  int errors = 0;
  int checks = 0;

  event_queue #(.DEPTH(8), .ADDR_W(3), .DATA_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .evtFlagA  (evtFlagA),
    .evtCodeA  (evtCodeA),
    .evtFlagB  (evtFlagB),
    .evtCodeB  (evtCodeB),
    .rdReq     (rdReq),
    .clrOvf    (clrOvf),
    .rdData    (rdData),
    .dataValid (dataValid),
    .irq       (irq),
    .overflow  (overflow),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic writeA(input logic [7:0] code);
    evtFlagA = 1'b1;
    evtCodeA = code;
    step();
    evtFlagA = 1'b0;
  endtask

  // Rising edge of rdReq pops on the 3rd posedge; then release and let the
  // synchronizer settle so the next call produces a fresh rising edge.
  task automatic popOne();
    rdReq = 1'b1;
    repeat (3) step();
    rdReq = 1'b0;
    repeat (3) step();
  endtask

  initial begin
    rst = 1'b1; evtFlagA = 1'b0; evtCodeA = '0; evtFlagB = 1'b0; evtCodeB = '0;
    rdReq = 1'b0; clrOvf = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("rst count", count, 0);
    chk("rst dataValid", dataValid, 0);
    chk("rst irq", irq, 0);
    chk("rst overflow", overflow, 0);
    chk("rst rdData", rdData, 0);

    // Single A event, FWFT visibility and read latency.
    writeA(8'h60);
    chk("t1 count", count, 1);
    chk("t1 dataValid", dataValid, 1);
    chk("t1 irq", irq, 1);
    chk("t1 rdData", rdData, 8'h60);
    rdReq = 1'b1;
    repeat (2) step();
    chk("t1 no pop at edge2", count, 1);
    step();
    chk("t1 pop at edge3", count, 0);
    chk("t1 rdData empty", rdData, 0);
    chk("t1 irq empty", irq, 0);
    rdReq = 1'b0;
    repeat (3) step();

    // A and B together: A first, B parked then written next cycle.
    evtFlagA = 1'b1; evtCodeA = 8'hA0; evtFlagB = 1'b1; evtCodeB = 8'h61;
    step();
    evtFlagA = 1'b0; evtFlagB = 1'b0;
    chk("t2 count c+1", count, 1);
    chk("t2 head c+1", rdData, 8'hA0);
    step();
    chk("t2 count c+2", count, 2);
    popOne();
    chk("t2 second", rdData, 8'h61);
    popOne();
    chk("t2 drained", count, 0);

    // Fill to full, 9th write dropped while clrOvf is pulsed (set wins).
    for (int i = 1; i <= 8; i++) writeA(8'(i));
    chk("t3 full count", count, 8);
    chk("t3 no ovf yet", overflow, 0);
    clrOvf = 1'b1;
    writeA(8'h09);
    clrOvf = 1'b0;
    chk("t3 count after drop", count, 8);
    chk("t3 overflow set", overflow, 1);
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("t3 read%0d", i), rdData, 32'(i));
      popOne();
    end
    chk("t3 empty", count, 0);
    clrOvf = 1'b1;
    step();
    clrOvf = 1'b0;
    chk("t3 overflow cleared", overflow, 0);

    // Full plus simultaneous write and pop.
    for (int i = 1; i <= 8; i++) writeA(8'(8'h10 + i));
    rdReq = 1'b1;
    repeat (2) step();
    evtFlagA = 1'b1; evtCodeA = 8'h99;
    step();
    evtFlagA = 1'b0; rdReq = 1'b0;
    chk("t4 count", count, 8);
    chk("t4 overflow", overflow, 0);
    repeat (3) step();
    for (int i = 2; i <= 8; i++) begin
      chk($sformatf("t4 read%0d", i), rdData, 32'(8'h10 + i));
      popOne();
    end
    chk("t4 last", rdData, 8'h99);
    popOne();
    chk("t4 empty", count, 0);

    // A three cycles, B in cycles 1 and 2: B#2 dropped.
    evtFlagA = 1'b1; evtCodeA = 8'hA1; evtFlagB = 1'b1; evtCodeB = 8'hB1;
    step();
    evtCodeA = 8'hA2; evtCodeB = 8'hB2;
    step();
    evtCodeA = 8'hA3; evtFlagB = 1'b0;
    step();
    evtFlagA = 1'b0;
    chk("t5 count before park", count, 3);
    step();
    chk("t5 count", count, 4);
    chk("t5 overflow", overflow, 1);
    chk("t5 e0", rdData, 8'hA1); popOne();
    chk("t5 e1", rdData, 8'hA2); popOne();
    chk("t5 e2", rdData, 8'hA3); popOne();
    chk("t5 e3", rdData, 8'hB1); popOne();
    chk("t5 empty", count, 0);
    clrOvf = 1'b1; step(); clrOvf = 1'b0;

    // Parked B drains before a newer lone B, which is then parked.
    evtFlagA = 1'b1; evtCodeA = 8'h31; evtFlagB = 1'b1; evtCodeB = 8'hC1;
    step();
    evtFlagA = 1'b0; evtCodeB = 8'hC2;
    step();
    evtFlagB = 1'b0;
    step();
    chk("t5b count", count, 3);
    chk("t5b overflow", overflow, 0);
    chk("t5b e0", rdData, 8'h31); popOne();
    chk("t5b e1", rdData, 8'hC1); popOne();
    chk("t5b e2", rdData, 8'hC2); popOne();

    // Held rdReq pops exactly once.
    writeA(8'h41); writeA(8'h42); writeA(8'h43);
    rdReq = 1'b1;
    repeat (20) step();
    rdReq = 1'b0;
    repeat (3) step();
    chk("t6 held count", count, 2);
    chk("t6 held head", rdData, 8'h42);
    popOne(); popOne();
    chk("t6 drained", count, 0);
    popOne(); popOne();
    chk("t6 empty pop count", count, 0);
    chk("t6 empty pop ovf", overflow, 0);
    chk("t6 empty pop valid", dataValid, 0);

    // Asynchronous reset mid-fill.
    writeA(8'h51); writeA(8'h52);
    evtFlagA = 1'b1; evtCodeA = 8'h53; evtFlagB = 1'b1; evtCodeB = 8'h54;
    #2;
    rst = 1'b1;
    #1;
    chk("t7 rst count", count, 0);
    chk("t7 rst irq", irq, 0);
    chk("t7 rst rdData", rdData, 0);
    evtFlagA = 1'b0; evtFlagB = 1'b0;
    step();
    rst = 1'b0;
    repeat (2) step();
    chk("t7 no parked B", count, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
